// File: rtl/keypad_scanner_db.sv
// Matrix keypad scanner: drives one row at a time, classifies each full frame,
// and debounces single-key presses and releases into a ready/valid key stream.
module keypad_scanner_db #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 3,
  localparam int CW      = $clog2(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [COLS-1:0] col_in,
  output logic [ROWS-1:0] row_drv,
  output logic [CW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            key_held,
  output logic            key_rel,
  output logic            overrun,
  input  logic            clr_ovr
);

  localparam int DW  = $clog2(SCAN_DIV);
  localparam int RW  = $clog2(ROWS);
  localparam int CLW = $clog2(COLS);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    PRESSED,
    REL_DB
  } state_t;

  logic [COLS-1:0] sync1_q, sync2_q;
  logic [DW-1:0]   div_q, div_d;
  logic [RW-1:0]   row_q, row_d;
  logic [1:0]      accCnt_q, accCnt_d;
  logic [CW-1:0]   accCode_q, accCode_d;
  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [CW-1:0]   cand_q, cand_d;
  logic [CW-1:0]   keyCode_q, keyCode_d;
  logic            keyValid_q, keyValid_d;
  logic            keyRel_q, keyRel_d;
  logic            overrun_q, overrun_d;

  logic            tick, lastRow, frameEnd;
  logic [1:0]      sampCnt;
  logic [CLW-1:0]  sampCol;
  logic [CW-1:0]   sampCode;
  logic [1:0]      frameCnt;
  logic [CW-1:0]   frameCode;
  logic            isNone, isSingle, isMatch;
  logic [3:0]      cntInc;
  logic            cntDone;
  logic            pressEv, relEv;

  assign tick     = (div_q == DW'(SCAN_DIV - 1));
  assign lastRow  = (row_q == RW'(ROWS - 1));
  assign frameEnd = tick && lastRow;

  always_comb begin
    row_drv        = '0;
    row_drv[row_q] = 1'b1;
  end

  // Count set column bits (saturating at 2) and remember the lowest one.
  always_comb begin
    sampCnt = 2'd0;
    sampCol = '0;
    for (int j = 0; j < COLS; j++) begin
      if (sync2_q[j]) begin
        if (sampCnt == 2'd0) sampCol = CLW'(j);
        if (sampCnt != 2'd2) sampCnt = sampCnt + 2'd1;
      end
    end
    sampCode = CW'(row_q) * CW'(COLS) + CW'(sampCol);
  end

  // Merge this row's sample into the running frame classification.
  always_comb begin
    if ((3'(accCnt_q) + 3'(sampCnt)) >= 3'd2) frameCnt = 2'd2;
    else                                      frameCnt = accCnt_q + sampCnt;
    frameCode = (accCnt_q != 2'd0) ? accCode_q : sampCode;
  end

  always_comb begin
    div_d     = tick ? '0 : div_q + DW'(1);
    row_d     = row_q;
    accCnt_d  = accCnt_q;
    accCode_d = accCode_q;
    if (tick) begin
      row_d     = lastRow ? '0 : row_q + RW'(1);
      accCnt_d  = lastRow ? 2'd0 : frameCnt;
      accCode_d = lastRow ? '0 : frameCode;
    end
  end

  assign isNone   = (frameCnt == 2'd0);
  assign isSingle = (frameCnt == 2'd1);
  assign isMatch  = isSingle && (frameCode == cand_q);
  assign cntInc   = cnt_q + 4'd1;
  assign cntDone  = (cntInc == 4'(DEBOUNCE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    pressEv = 1'b0;
    relEv   = 1'b0;
    if (frameEnd) begin
      case (state_q)
        IDLE: begin
          if (isSingle) begin
            cand_d = frameCode;
            cnt_d  = 4'd1;
            if (DEBOUNCE == 1) begin
              state_d = PRESSED;
              pressEv = 1'b1;
            end else begin
              state_d = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (isMatch) begin
            cnt_d = cntInc;
            if (cntDone) begin
              state_d = PRESSED;
              pressEv = 1'b1;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        end
        PRESSED: begin
          if (!isMatch) begin
            if (DEBOUNCE == 1) begin
              state_d = IDLE;
              cnt_d   = 4'd0;
              relEv   = 1'b1;
            end else begin
              state_d = REL_DB;
              cnt_d   = 4'd1;
            end
          end
        end
        REL_DB: begin
          if (isNone) begin
            cnt_d = cntInc;
            if (cntDone) begin
              state_d = IDLE;
              cnt_d   = 4'd0;
              relEv   = 1'b1;
            end
          end else if (isMatch) begin
            state_d = PRESSED;
          end else begin
            cnt_d = 4'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A press arriving while the previous key is still unconsumed is dropped and flagged.
  always_comb begin
    keyCode_d  = keyCode_q;
    keyValid_d = keyValid_q;
    overrun_d  = overrun_q;
    keyRel_d   = relEv;
    if (keyValid_q && key_ready) keyValid_d = 1'b0;
    if (clr_ovr) overrun_d = 1'b0;
    if (pressEv) begin
      if (!keyValid_q || key_ready) begin
        keyCode_d  = cand_d;
        keyValid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      div_q      <= '0;
      row_q      <= '0;
      accCnt_q   <= 2'd0;
      accCode_q  <= '0;
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      cand_q     <= '0;
      keyCode_q  <= '0;
      keyValid_q <= 1'b0;
      keyRel_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q    <= col_in;
      sync2_q    <= sync1_q;
      div_q      <= div_d;
      row_q      <= row_d;
      accCnt_q   <= accCnt_d;
      accCode_q  <= accCode_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      keyCode_q  <= keyCode_d;
      keyValid_q <= keyValid_d;
      keyRel_q   <= keyRel_d;
      overrun_q  <= overrun_d;
    end
  end

  assign key_code  = keyCode_q;
  assign key_valid = keyValid_q;
  assign key_rel   = keyRel_q;
  assign overrun   = overrun_q;
  assign key_held  = (state_q == PRESSED) || (state_q == REL_DB);

endmodule

// File: tb/tb_keypad_scanner_db.sv
// Directed bench for keypad_scanner_db: a 4x4 key matrix model driven by row_drv,
// frame-aligned stimulus, and a queue of expected key codes.
module tb_keypad_scanner_db;

  logic        clk;
  logic        rst_n;
  logic [3:0]  col_in;
  logic [3:0]  row_drv;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        key_held;
  logic        key_rel;
  logic        overrun;
  logic        clr_ovr;

  logic [15:0] keys;
  logic [3:0]  expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc;

  keypad_scanner_db #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .col_in(col_in), .row_drv(row_drv),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .key_held(key_held), .key_rel(key_rel), .overrun(overrun), .clr_ovr(clr_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: a pressed key connects its row line to its column line.
  always_comb begin
    col_in = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (row_drv[i] && keys[i*4+j]) col_in[j] = 1'b1;
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] k, input logic rdy);
    keys      = k;
    key_ready = rdy;
  endtask

  task automatic nextFrameEnd();
    int guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while ((cyc % 16) != 0 && guard < 40);
    if ((cyc % 16) != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL frame_align observed=%0d expected=0", cyc % 16);
    end
  endtask

  task automatic checkKey(input string tag);
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      checkOutput({tag, "_valid"}, key_valid, 1);
      checkOutput({tag, "_code"}, key_code, expQ[0]);
    end
  endtask

  task automatic consume(input string tag);
    key_ready = 1'b1;
    @(posedge clk); #1;
    key_ready = 1'b0;
    checkOutput({tag, "_cleared"}, key_valid, 0);
    if (expQ.size() > 0) void'(expQ.pop_front());
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_row_drv"}, row_drv, 4'b0001);
    checkOutput({tag, "_key_code"}, key_code, 0);
    checkOutput({tag, "_key_valid"}, key_valid, 0);
    checkOutput({tag, "_key_held"}, key_held, 0);
    checkOutput({tag, "_key_rel"}, key_rel, 0);
    checkOutput({tag, "_overrun"}, overrun, 0);
  endtask

  // Release keys and expect the release pulse on the third empty frame.
  task automatic releaseAll(input string tag);
    applyStimulus(16'h0000, 1'b0);
    nextFrameEnd();
    checkOutput({tag, "_held1"}, key_held, 1);
    nextFrameEnd();
    checkOutput({tag, "_rel2"}, key_rel, 0);
    nextFrameEnd();
    checkOutput({tag, "_rel3"}, key_rel, 1);
    checkOutput({tag, "_held3"}, key_held, 0);
    @(posedge clk); #1;
    checkOutput({tag, "_rel_end"}, key_rel, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    keys      = '0;
    key_ready = 1'b0;
    clr_ovr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk) rst_n = 1'b1;

    // Key 6 (row 1, column 2) held steadily.
    applyStimulus(16'h0040, 1'b0);
    expQ.push_back(4'd6);
    nextFrameEnd();
    checkOutput("p1_valid", key_valid, 0);
    checkOutput("p1_held", key_held, 0);
    nextFrameEnd();
    checkOutput("p2_valid", key_valid, 0);
    nextFrameEnd();
    checkKey("p3");
    checkOutput("p3_held", key_held, 1);
    consume("p3");
    releaseAll("r");

    // Key 6 with a one-frame dropout must restart the debounce count.
    applyStimulus(16'h0040, 1'b0);
    nextFrameEnd();
    applyStimulus(16'h0000, 1'b0);
    nextFrameEnd();
    checkOutput("g2_held", key_held, 0);
    applyStimulus(16'h0040, 1'b0);
    expQ.push_back(4'd6);
    nextFrameEnd();
    nextFrameEnd();
    checkOutput("g4_valid", key_valid, 0);
    nextFrameEnd();
    checkKey("g5");
    consume("g5");
    releaseAll("gr");

    // Keys 6 and 9 together: every frame is MULTI, nothing is emitted.
    applyStimulus(16'h0240, 1'b0);
    for (int f = 0; f < 3; f++) begin
      nextFrameEnd();
      checkOutput("m_valid", key_valid, 0);
      checkOutput("m_held", key_held, 0);
    end
    applyStimulus(16'h0000, 1'b0);
    for (int f = 0; f < 3; f++) begin
      nextFrameEnd();
      checkOutput("m_rel", key_rel, 0);
      checkOutput("m_rel_valid", key_valid, 0);
    end

    // Unconsumed key 6, then key 9 pressed: 9 is dropped and overrun set.
    applyStimulus(16'h0040, 1'b0);
    expQ.push_back(4'd6);
    repeat (3) nextFrameEnd();
    checkKey("o_first");
    releaseAll("or");
    applyStimulus(16'h0200, 1'b0);
    repeat (3) nextFrameEnd();
    checkKey("o_keep");
    checkOutput("o_overrun", overrun, 1);
    checkOutput("o_held", key_held, 1);
    clr_ovr = 1'b1;
    @(posedge clk); #1;
    clr_ovr = 1'b0;
    checkOutput("o_clr", overrun, 0);
    releaseAll("or9");
    checkOutput("pend_valid", key_valid, 1);

    // Reset in the middle of a press debounce with a key still pending.
    applyStimulus(16'h0040, 1'b0);
    repeat (2) nextFrameEnd();
    checkOutput("d2_held", key_held, 0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midrst");
    expQ.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    expQ.push_back(4'd6);
    nextFrameEnd();
    checkOutput("a1_valid", key_valid, 0);
    nextFrameEnd();
    checkOutput("a2_valid", key_valid, 0);
    nextFrameEnd();
    checkKey("a3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner_db.md
KEYPAD_SCANNER_DB -- requirements
Module: keypad_scanner_db

Interface
REQ-001 SHALL have parameter ROWS, default 4: number of driven rows, 2..8.
REQ-002 SHALL have parameter COLS, default 4: number of sensed columns, 2..8.
REQ-003 SHALL have parameter SCAN_DIV, default 50000: clocks per row slot, >=3.
REQ-004 SHALL have parameter DEBOUNCE, default 3: consecutive identical frames required to accept a press or release, 1..15.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port col_in, input, COLS bits: asynchronous column sense; bit j high = key in column j pressed on the driven row.
REQ-008 SHALL have port row_drv, output, ROWS bits: one-hot active-high row drive.
REQ-009 SHALL have port key_code, output, CW = clog2(ROWS*COLS) bits: accepted key index = row*COLS + col.
REQ-010 SHALL have port key_valid, output, 1 bit: key_code holds an unconsumed press.
REQ-011 SHALL have port key_ready, input, 1 bit: consumer accepts key_code when high with key_valid.
REQ-012 SHALL have port key_held, output, 1 bit: level; high while FSM is in PRESSED or REL_DB.
REQ-013 SHALL have port key_rel, output, 1 bit: one-clock pulse on accepted release.
REQ-014 SHALL have port overrun, output, 1 bit: sticky flag for a dropped press.
REQ-015 SHALL have port clr_ovr, input, 1 bit: synchronous clear of overrun.

Function
REQ-016 SHALL pass col_in through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-017 SHALL run a divider 0..SCAN_DIV-1; tick = divider at SCAN_DIV-1; divider wraps to 0.
REQ-018 SHALL sample the synchronized columns for the current row on tick, then advance the row index; index wraps ROWS-1 -> 0; row_drv = one-hot of row index.
REQ-019 SHALL classify each frame (ROWS ticks, row 0..ROWS-1) as NONE (no bits), SINGLE(code) (exactly one bit in the whole frame), or MULTI (more than one); classification includes the sample taken on the final tick.
REQ-020 SHALL update the FSM only on the tick that ends a frame (row index ROWS-1).
REQ-021 IDLE: SINGLE(c) -> cand=c, cnt=1; DEBOUNCE=1 -> PRESSED immediately, else -> PRESS_DB; NONE/MULTI -> stay.
REQ-022 PRESS_DB: SINGLE(cand) -> cnt+1; cnt+1 == DEBOUNCE -> PRESSED; any other class -> IDLE, cnt=0.
REQ-023 PRESSED: SINGLE(cand) -> stay; any other class -> cnt=1, REL_DB (DEBOUNCE=1 -> IDLE with release).
REQ-024 REL_DB: NONE -> cnt+1; cnt+1 == DEBOUNCE -> IDLE, key_rel pulse; SINGLE(cand) -> PRESSED, no new press event; SINGLE(other)/MULTI -> cnt=0, stay.
REQ-025 Entering PRESSED from PRESS_DB or IDLE SHALL be a press event; on it, if key_valid is low or (key_valid and key_ready) in the same clock, key_code=cand and key_valid=1.
REQ-026 On a press event with key_valid high and key_ready low, SHALL keep the old key_code, drop the new one, and set overrun=1.
REQ-027 key_valid SHALL clear the clock after key_valid and key_ready are both high, unless a press event reloads it in that same clock (REQ-025).
REQ-028 clr_ovr SHALL clear overrun; a press event setting overrun in the same clock takes priority.
REQ-029 key_rel SHALL be high exactly one clock; key_held SHALL be combinationally derived from state.

Reset
REQ-030 While rst_n is low: divider=0, row index=0, row_drv=1 (row 0), synchronizers=0, state=IDLE, cnt=0, cand=0, key_code=0, key_valid=0, key_held=0, key_rel=0, overrun=0.
REQ-031 Reset asserted mid-debounce or with key_valid pending SHALL discard all in-flight state; the first frame after release starts at row 0.

Verification (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3; frame = 16 clk)
REQ-032 Hold col_in[2] high only while row 1 is driven -> key_valid=1, key_code=6 at the 3rd frame-end tick; key_held=1.
REQ-033 Same press, dropped in frame 2, then stable -> no key_valid until 3 fresh consecutive SINGLE(6) frames.
REQ-034 Keys 6 and 9 pressed together -> MULTI each frame; key_valid stays 0; release both -> nothing emitted.
REQ-035 key_ready=0; press 6, release, then press 9 -> key_code stays 6, overrun=1; pulse clr_ovr -> overrun=0.
REQ-036 Release key 6 after acceptance -> key_rel one-clock pulse at 3rd NONE frame-end; key_held falls the same clock.
REQ-037 rst_n low during PRESS_DB after 2 frames -> all outputs at reset values; row_drv=0001 immediately.
